// File: rtl/regfiletmp_retire.sv
// In-order retirement engine for the temporary register file.
// Holds allocated temp-file tags in program order, reads the head entry,
// commits ready results to the architectural register file and returns
// tags to the free pool. A flush drains every outstanding tag without
// architectural writes.
module regfiletmp_retire #(
  parameter int DEPTH   = 32,
  parameter int TAG_W   = 5,
  parameter int ENTRY_W = 73
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               alloc_valid_i,
  input  logic [TAG_W-1:0]   alloc_tag_i,
  output logic               alloc_ready_o,
  input  logic               flush_i,
  output logic [TAG_W-1:0]   rd_addr_o,
  input  logic [ENTRY_W-1:0] rd_data_i,
  output logic               arf_we_o,
  output logic [4:0]         arf_waddr_o,
  output logic [31:0]        arf_wdata_o,
  output logic [31:0]        commit_pc_o,
  output logic               free_valid_o,
  output logic [TAG_W-1:0]   free_tag_o,
  output logic [31:0]        commit_cnt_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  // Entry fields as seen on the read port
  logic [4:0]  e_rd_reg;
  logic [31:0] e_pc;
  logic [1:0]  e_type;
  logic [31:0] e_data;
  logic        e_spec_valid;
  logic        e_valid;

  assign e_rd_reg     = rd_data_i[72:68];
  assign e_pc         = rd_data_i[67:36];
  assign e_type       = rd_data_i[35:34];
  assign e_data       = rd_data_i[33:2];
  assign e_spec_valid = rd_data_i[1];
  assign e_valid      = rd_data_i[0];

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   q_mem [DEPTH];
  logic [TAG_W-1:0]   head_q, head_d;
  logic [TAG_W-1:0]   tail_q, tail_d;
  logic [TAG_W:0]     count_q, count_d;

  logic               arf_we_q;
  logic [4:0]         arf_waddr_q;
  logic [31:0]        arf_wdata_q;
  logic [31:0]        commit_pc_q;
  logic               free_valid_q;
  logic [TAG_W-1:0]   free_tag_q;
  logic [31:0]        commit_cnt_q;

  logic push, pop, retire, drain, writes_arf;

  // Push/pop decisions; the push is gated on the pre-pop count so a full
  // queue refuses a push even in a cycle where the head leaves.
  always_comb begin
    alloc_ready_o = (state_q != FLUSH) && (count_q < DEPTH_C);
    push          = alloc_valid_i && alloc_ready_o;
    retire        = (state_q == RUN) && e_valid && e_spec_valid && !flush_i;
    drain         = (state_q == FLUSH);
    pop           = retire || drain;
    writes_arf    = !e_type[1] && (e_rd_reg != 5'd0);
  end

  // Next pointers, count and state
  always_comb begin
    head_d  = pop  ? head_q + TAG_W'(1) : head_q;
    tail_d  = push ? tail_q + TAG_W'(1) : tail_q;
    count_d = count_q + (TAG_W+1)'(push) - (TAG_W+1)'(pop);
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = RUN;
      RUN: begin
        if (flush_i)                 state_d = FLUSH;
        else if (count_d == '0)      state_d = IDLE;
      end
      FLUSH:   if (count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag storage; contents need no reset since pointers define validity
  always_ff @(posedge clock_i) begin
    if (push) q_mem[tail_q] <= alloc_tag_i;
  end

  // Queue control, FSM and registered commit/free outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      arf_we_q     <= 1'b0;
      arf_waddr_q  <= '0;
      arf_wdata_q  <= '0;
      commit_pc_q  <= '0;
      free_valid_q <= 1'b0;
      free_tag_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      arf_we_q     <= retire && writes_arf;
      free_valid_q <= pop;
      if (pop) free_tag_q <= rd_addr_o;
      if (retire) begin
        arf_waddr_q  <= e_rd_reg;
        arf_wdata_q  <= e_data;
        commit_pc_q  <= e_pc;
        commit_cnt_q <= commit_cnt_q + 32'd1;
      end
    end
  end

  assign rd_addr_o    = q_mem[head_q];
  assign arf_we_o     = arf_we_q;
  assign arf_waddr_o  = arf_waddr_q;
  assign arf_wdata_o  = arf_wdata_q;
  assign commit_pc_o  = commit_pc_q;
  assign free_valid_o = free_valid_q;
  assign free_tag_o   = free_tag_q;
  assign commit_cnt_o = commit_cnt_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_regfiletmp_retire.sv
// Directed bench for regfiletmp_retire; the temp file is a bench-side array
// indexed by the DUT read address.
module tb_regfiletmp_retire;

  logic        clock = 1'b0;
  logic        reset, alloc_valid, flush;
  logic [4:0]  alloc_tag;
  logic        alloc_ready;
  logic [4:0]  rd_addr;
  logic [72:0] rd_data;
  logic        arf_we, free_valid, busy;
  logic [4:0]  arf_waddr, free_tag;
  logic [31:0] arf_wdata, commit_pc, commit_cnt;

  logic [72:0] ent [32];

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  assign rd_data = ent[rd_addr];

  regfiletmp_retire dut (
    .clock_i(clock), .reset_i(reset),
    .alloc_valid_i(alloc_valid), .alloc_tag_i(alloc_tag), .alloc_ready_o(alloc_ready),
    .flush_i(flush), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .arf_we_o(arf_we), .arf_waddr_o(arf_waddr), .arf_wdata_o(arf_wdata),
    .commit_pc_o(commit_pc), .free_valid_o(free_valid), .free_tag_o(free_tag),
    .commit_cnt_o(commit_cnt), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [72:0] mk(input logic [4:0] rd, input logic [31:0] pc,
                                     input logic [1:0] ty, input logic [31:0] d,
                                     input logic sv, input logic v);
    return {rd, pc, ty, d, sv, v};
  endfunction

  initial begin
    int pulses;
    logic saw_we;
    for (int i = 0; i < 32; i++) ent[i] = '0;
    reset = 1'b1; alloc_valid = 1'b0; alloc_tag = '0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_we",    {31'd0, arf_we}, 32'd0);
    chk("rst_fv",    {31'd0, free_valid}, 32'd0);
    chk("rst_cnt",   commit_cnt, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, alloc_ready}, 32'd1);
    chk("rst_pc",    commit_pc, 32'd0);
    chk("rst_wdata", arf_wdata, 32'd0);

    // basic commit of tag 3, tag 7 queued behind
    ent[3] = mk(5'd5, 32'h100, 2'b00, 32'hDEADBEEF, 1'b1, 1'b1);
    ent[7] = mk(5'd6, 32'h104, 2'b00, 32'h1234, 1'b0, 1'b1);
    alloc_valid = 1'b1; alloc_tag = 5'd3; tick();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_rdaddr3", {27'd0, rd_addr}, 32'd3);
    alloc_tag = 5'd7; tick();
    alloc_valid = 1'b0;
    chk("t1_we",    {31'd0, arf_we}, 32'd1);
    chk("t1_waddr", {27'd0, arf_waddr}, 32'd5);
    chk("t1_wdata", arf_wdata, 32'hDEADBEEF);
    chk("t1_pc",    commit_pc, 32'h100);
    chk("t1_fv",    {31'd0, free_valid}, 32'd1);
    chk("t1_ftag",  {27'd0, free_tag}, 32'd3);
    chk("t1_cnt",   commit_cnt, 32'd1);
    chk("t1_rdaddr7", {27'd0, rd_addr}, 32'd7);

    // head 7 stalls 4 cycles, tag 9 pushed behind it
    ent[9] = '0;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = (i == 0); alloc_tag = 5'd9;
      tick();
      chk("t2_stall_fv", {31'd0, free_valid}, 32'd0);
      chk("t2_stall_we", {31'd0, arf_we}, 32'd0);
    end
    alloc_valid = 1'b0;
    ent[7][1] = 1'b1;
    tick();
    chk("t2_we",    {31'd0, arf_we}, 32'd1);
    chk("t2_waddr", {27'd0, arf_waddr}, 32'd6);
    chk("t2_wdata", arf_wdata, 32'h1234);
    chk("t2_ftag",  {27'd0, free_tag}, 32'd7);
    chk("t2_cnt",   commit_cnt, 32'd2);
    chk("t2_rdaddr9", {27'd0, rd_addr}, 32'd9);
    tick();
    chk("t2_single", {31'd0, free_valid}, 32'd0);
    chk("t2_queued", {31'd0, busy}, 32'd1);

    // store and rd=0 ALU: free but no ARF write; push+pop same cycle
    ent[9]  = mk(5'd4, 32'h200, 2'b10, 32'h55, 1'b1, 1'b1);
    ent[11] = mk(5'd0, 32'h204, 2'b00, 32'h66, 1'b1, 1'b1);
    alloc_valid = 1'b1; alloc_tag = 5'd11; tick();
    alloc_valid = 1'b0;
    chk("t3_st_fv",   {31'd0, free_valid}, 32'd1);
    chk("t3_st_we",   {31'd0, arf_we}, 32'd0);
    chk("t3_st_ftag", {27'd0, free_tag}, 32'd9);
    chk("t3_st_pc",   commit_pc, 32'h200);
    tick();
    chk("t3_r0_fv",   {31'd0, free_valid}, 32'd1);
    chk("t3_r0_we",   {31'd0, arf_we}, 32'd0);
    chk("t3_r0_ftag", {27'd0, free_tag}, 32'd11);
    chk("t3_cnt",     commit_cnt, 32'd4);
    chk("t3_idle",    {31'd0, busy}, 32'd0);
    tick();
    chk("t3_quiet",   {31'd0, free_valid}, 32'd0);

    // fill 32 unready tags
    for (int i = 0; i < 32; i++) ent[i] = '0;
    for (int i = 0; i < 32; i++) begin
      alloc_valid = 1'b1; alloc_tag = 5'(i); tick();
    end
    alloc_valid = 1'b0;
    chk("t4_full", {31'd0, alloc_ready}, 32'd0);
    chk("t4_head", {27'd0, rd_addr}, 32'd0);
    // head (load, rd=7) retires while a push is offered: push refused
    ent[0] = mk(5'd7, 32'h300, 2'b01, 32'hCAFE, 1'b1, 1'b1);
    alloc_valid = 1'b1; alloc_tag = 5'd0; tick();
    alloc_valid = 1'b0;
    ent[0] = '0;
    chk("t4_ld_we",   {31'd0, arf_we}, 32'd1);
    chk("t4_ld_addr", {27'd0, arf_waddr}, 32'd7);
    chk("t4_ld_data", arf_wdata, 32'hCAFE);
    chk("t4_cnt",     commit_cnt, 32'd5);
    chk("t4_ready31", {31'd0, alloc_ready}, 32'd1);
    chk("t4_head1",   {27'd0, rd_addr}, 32'd1);
    // drain the remaining entries; exactly 31 must come back
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4_fl_fv0", {31'd0, free_valid}, 32'd0);
    pulses = 0; saw_we = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (free_valid) pulses++;
      if (arf_we) saw_we = 1'b1;
      if (!busy) break;
    end
    chk("t4_drain31", pulses, 32'd31);
    chk("t4_drain_we", {31'd0, saw_we}, 32'd0);
    chk("t4_drain_idle", {31'd0, busy}, 32'd0);

    // 5 queued, flush drains in head order
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_tag = 5'(20 + i); tick();
    end
    alloc_valid = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t5_fl_fv",    {31'd0, free_valid}, 32'd0);
    chk("t5_fl_ready", {31'd0, alloc_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_fv",   {31'd0, free_valid}, 32'd1);
      chk("t5_ftag", {27'd0, free_tag}, 32'(20 + i));
      chk("t5_we",   {31'd0, arf_we}, 32'd0);
      if (i < 4) chk("t5_rdy_drain", {31'd0, alloc_ready}, 32'd0);
    end
    chk("t5_idle",  {31'd0, busy}, 32'd0);
    chk("t5_rdy",   {31'd0, alloc_ready}, 32'd1);
    chk("t5_cnt",   commit_cnt, 32'd5);
    tick();
    chk("t5_quiet", {31'd0, free_valid}, 32'd0);

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_tag = 5'(12 + i); tick();
    end
    alloc_valid = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("t6_mid_fv", {31'd0, free_valid}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_fv",    {31'd0, free_valid}, 32'd0);
    chk("t6_we",    {31'd0, arf_we}, 32'd0);
    chk("t6_ftag",  {27'd0, free_tag}, 32'd0);
    chk("t6_pc",    commit_pc, 32'd0);
    chk("t6_waddr", {27'd0, arf_waddr}, 32'd0);
    chk("t6_cnt",   commit_cnt, 32'd0);
    chk("t6_busy",  {31'd0, busy}, 32'd0);
    chk("t6_rdy",   {31'd0, alloc_ready}, 32'd1);
    tick();
    chk("t6_nodrain", {31'd0, free_valid}, 32'd0);
    // queue is empty: a new push lands at the head and commits
    ent[2] = mk(5'd9, 32'h400, 2'b00, 32'h77, 1'b1, 1'b1);
    alloc_valid = 1'b1; alloc_tag = 5'd2; tick();
    alloc_valid = 1'b0;
    chk("t6_head", {27'd0, rd_addr}, 32'd2);
    tick();
    chk("t6_post_ftag", {27'd0, free_tag}, 32'd2);
    chk("t6_post_cnt",  commit_cnt, 32'd1);
    chk("t6_post_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfiletmp_retire.md
Name: regfiletmp_retire

Overview:
- In-order retirement engine on the read side of the temporary (speculative) register file.
- Keeps a program-order queue of allocated temp-file tags and drives a temp-file read port with the head tag.
- When the head entry's speculative result is ready, writes it to the architectural register file and returns the tag to the free pool.
- On a flush, it drains all outstanding tags to the free pool without architectural writes.

Parameters:
- DEPTH, 32, order-queue entries; power of two; equals the temp-file entry count.
- TAG_W, 5, tag/address width; log2(DEPTH).
- ENTRY_W, 73, temp-file entry width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- alloc_valid  in  1  a tag was allocated in program order this cycle.
- alloc_tag  in  TAG_W  the allocated tag.
- alloc_ready  out  1  queue can accept a push (combinational).
- flush  in  1  mispredict/exception; discard all outstanding entries.
- rd_addr  out  TAG_W  temp-file read address; always the head tag.
- rd_data  in  ENTRY_W  temp-file entry at rd_addr (combinational, same cycle).
- arf_we  out  1  architectural register write strobe (registered).
- arf_waddr  out  5  destination register, from rd_data[72:68].
- arf_wdata  out  32  commit value, from rd_data[33:2].
- commit_pc  out  32  PC of the retired instruction, from rd_data[67:36].
- free_valid  out  1  tag-return strobe (registered).
- free_tag  out  TAG_W  tag being returned.
- commit_cnt  out  32  count of retired instructions; wraps at 2^32.
- busy  out  1  state != IDLE.

Behaviour:
- Entry field layout:
  - rd_reg = [72:68], PC = [67:36], inst_type = [35:34], spec_data = [33:2], spec_valid = [1], valid = [0].
  - inst_type encoding: 00 ALU, 01 load, 10 store, 11 branch. Only 00 and 01 write the architectural register file.
- Order queue: circular FIFO with head pointer, tail pointer and count.
  - count has TAG_W+1 bits.
  - Pointers wrap modulo DEPTH.
- Reset (clock edge with reset=1), highest priority:
  - Pointers and count = 0; state = IDLE.
  - arf_we = 0, free_valid = 0, arf_waddr = 0, arf_wdata = 0, commit_pc = 0, free_tag = 0, commit_cnt = 0.
  - Reset applies mid-drain or mid-commit; no partial pulse is emitted.
- alloc_ready = (state != FLUSH) && (count < DEPTH).
  - A push is decided on count before any same-cycle pop, so a full queue refuses a push even while it pops.
  - alloc_valid while alloc_ready = 0 is dropped.
- rd_addr = queue[head] in every state, including when the queue is empty.
- States:
  - IDLE: count == 0.
    - Push → RUN.
    - flush → stay in IDLE; no pulses.
  - RUN: count > 0, head waiting.
    - Retire condition: rd_data[0] && rd_data[1] && !flush.
    - On retire, at the next edge:
      - Pop the head.
      - free_valid = 1, free_tag = head.
      - commit_pc = rd_data[67:36].
      - commit_cnt += 1.
      - arf_we = 1 iff inst_type is 00 or 01 and rd_reg != 0.
      - arf_waddr and arf_wdata are loaded on every retire.
    - Throughput: one retire per cycle; latency is one cycle from the ready head to the strobes.
    - If the head is not ready: stall; strobes = 0.
    - A push and a pop in the same cycle are both applied; count is unchanged.
    - If count becomes 0 with no push → IDLE.
    - flush → FLUSH. No retire that cycle; a same-cycle push is still accepted.
  - FLUSH:
    - Each cycle: pop the head, free_valid = 1, free_tag = head, arf_we = 0, commit_cnt unchanged.
    - After the last pop → IDLE.
    - flush asserted while in FLUSH is ignored.
- Strobes are single-cycle; the strobe outputs are 0 in any cycle without a retire or drain pop.

Test Plan:
- Reset, then push tags 3,7; rd_data for tag 3 has valid=1, spec_valid=1, type=00, rd=5, data=0xDEADBEEF → next cycle arf_we=1, arf_waddr=5, arf_wdata=0xDEADBEEF, free_tag=3, commit_cnt=1; rd_addr becomes 7.
- Head tag 7 with spec_valid=0 for 4 cycles, then 1 → no strobes for 4 cycles, then a single commit; the younger tag behind it stays queued.
- Retire a store (type 10) and an ALU op with rd=0 → free_valid=1 on both, arf_we=0 on both, commit_cnt += 2.
- Push 32 tags → alloc_ready=0; push while the head retires → the push is refused and count = 31 after that edge.
- With 5 queued and flush=1 → 5 consecutive free_valid pulses in head order, arf_we=0 throughout, alloc_ready=0 during the drain, then IDLE with busy=0.
- Pulse reset during the FLUSH drain → next cycle all outputs = 0, count = 0, state IDLE.
